// File: rtl/inert_reader.sv
// IMU read sequencer: waits out power-up, configures the IMU over SPI, then assembles
// pitch rate and Z acceleration on each data-ready interrupt. Define INERT_TIMEOUT_EN for the SPI watchdog.
module inert_reader #(
    parameter int INIT_WAIT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               INT,
    input  logic               done,
    input  logic [15:0]        rd_data,
    output logic               wrt,
    output logic [15:0]        cmd,
    output logic               vld,
    output logic signed [15:0] ptch_rt,
    output logic signed [15:0] AZ,
    output logic               err
);

    typedef enum logic [3:0] {
        INIT_WAIT,
        INIT1,
        INIT2,
        INIT3,
        INIT4,
        IDLE,
        RD_PL,
        RD_PH,
        RD_AL,
        RD_AH
    } state_t;

    localparam logic [15:0] CMD_INT_CFG  = 16'h0D02;
    localparam logic [15:0] CMD_ACC_ODR  = 16'h1053;
    localparam logic [15:0] CMD_GYR_ODR  = 16'h1150;
    localparam logic [15:0] CMD_ROUNDING = 16'h1460;
    localparam logic [15:0] CMD_RD_PL    = 16'hA200;
    localparam logic [15:0] CMD_RD_PH    = 16'hA300;
    localparam logic [15:0] CMD_RD_AL    = 16'hAC00;
    localparam logic [15:0] CMD_RD_AH    = 16'hAD00;

    state_t                   state_q, state_d;
    logic [INIT_WAIT_W-1:0]   cnt_q, cnt_d;
    logic                     int_s1_q, int_s2_q, int_s3_q;
    logic                     int_rise;
    logic                     wrt_q, wrt_d;
    logic [15:0]              cmd_q, cmd_d;
    logic                     vld_q, vld_d;
    logic [15:0]              ptch_rt_q, ptch_rt_d;
    logic [15:0]              az_q, az_d;
    logic [7:0]               pl_q, pl_d;
    logic [7:0]               ph_q, ph_d;
    logic [7:0]               al_q, al_d;
    logic                     rd_data_unused;

    assign rd_data_unused = ^rd_data[15:8];

    // First two flops synchronize INT; the third remembers the previous level.
    assign int_rise = int_s2_q & ~int_s3_q;

`ifdef INERT_TIMEOUT_EN
    logic [9:0] wd_q, wd_d;
    logic       err_q, err_d;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        wrt_d     = 1'b0;
        cmd_d     = cmd_q;
        vld_d     = 1'b0;
        ptch_rt_d = ptch_rt_q;
        az_d      = az_q;
        pl_d      = pl_q;
        ph_d      = ph_q;
        al_d      = al_q;

        unique case (state_q)
            INIT_WAIT: begin
                cnt_d = cnt_q + INIT_WAIT_W'(1);
                if (&cnt_d) begin
                    wrt_d   = 1'b1;
                    cmd_d   = CMD_INT_CFG;
                    state_d = INIT1;
                end
            end
            INIT1: if (done) begin
                wrt_d   = 1'b1;
                cmd_d   = CMD_ACC_ODR;
                state_d = INIT2;
            end
            INIT2: if (done) begin
                wrt_d   = 1'b1;
                cmd_d   = CMD_GYR_ODR;
                state_d = INIT3;
            end
            INIT3: if (done) begin
                wrt_d   = 1'b1;
                cmd_d   = CMD_ROUNDING;
                state_d = INIT4;
            end
            INIT4: if (done) state_d = IDLE;
            IDLE: if (int_rise) begin
                wrt_d   = 1'b1;
                cmd_d   = CMD_RD_PL;
                state_d = RD_PL;
            end
            RD_PL: if (done) begin
                pl_d    = rd_data[7:0];
                wrt_d   = 1'b1;
                cmd_d   = CMD_RD_PH;
                state_d = RD_PH;
            end
            RD_PH: if (done) begin
                ph_d    = rd_data[7:0];
                wrt_d   = 1'b1;
                cmd_d   = CMD_RD_AL;
                state_d = RD_AL;
            end
            RD_AL: if (done) begin
                al_d    = rd_data[7:0];
                wrt_d   = 1'b1;
                cmd_d   = CMD_RD_AH;
                state_d = RD_AH;
            end
            RD_AH: if (done) begin
                // Both words move together so a partial sample is never visible.
                ptch_rt_d = {ph_q, pl_q};
                az_d      = {rd_data[7:0], al_q};
                vld_d     = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = INIT_WAIT;
        endcase

`ifdef INERT_TIMEOUT_EN
        wd_d  = '0;
        err_d = err_q;
        if (state_q inside {INIT1, INIT2, INIT3, INIT4, RD_PL, RD_PH, RD_AL, RD_AH} && !done) begin
            wd_d = wd_q + 10'd1;
            if (&wd_d) begin
                wd_d  = '0;
                err_d = 1'b1;
                // cmd_q still holds the lost write, so re-issuing only needs a new strobe.
                if (state_q inside {INIT1, INIT2, INIT3, INIT4}) wrt_d = 1'b1;
                else                                             state_d = IDLE;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q   <= INIT_WAIT;
            cnt_q     <= '0;
            int_s1_q  <= 1'b0;
            int_s2_q  <= 1'b0;
            int_s3_q  <= 1'b0;
            wrt_q     <= 1'b0;
            cmd_q     <= 16'h0000;
            vld_q     <= 1'b0;
            ptch_rt_q <= 16'h0000;
            az_q      <= 16'h0000;
            pl_q      <= 8'h00;
            ph_q      <= 8'h00;
            al_q      <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            int_s1_q  <= INT;
            int_s2_q  <= int_s1_q;
            int_s3_q  <= int_s2_q;
            wrt_q     <= wrt_d;
            cmd_q     <= cmd_d;
            vld_q     <= vld_d;
            ptch_rt_q <= ptch_rt_d;
            az_q      <= az_d;
            pl_q      <= pl_d;
            ph_q      <= ph_d;
            al_q      <= al_d;
        end
    end

`ifdef INERT_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign wrt     = wrt_q;
    assign cmd     = cmd_q;
    assign vld     = vld_q;
    assign ptch_rt = ptch_rt_q;
    assign AZ      = az_q;

endmodule

// File: tb/tb_inert_reader.sv
// Directed bench for inert_reader: a behavioural SPI slave answers each wrt after a fixed delay
// with register bytes chosen by the bench; the main sequence checks outputs against hand-computed values.
module tb_inert_reader;

    localparam int W       = 4;
    localparam int SPI_DLY = 20;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               INT = 1'b0;
    logic               done = 1'b0;
    logic [15:0]        rd_data = 16'h0000;
    logic               wrt;
    logic [15:0]        cmd;
    logic               vld;
    logic signed [15:0] ptch_rt;
    logic signed [15:0] AZ;
    logic               err;

    inert_reader #(.INIT_WAIT_W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .INT    (INT),
        .done   (done),
        .rd_data(rd_data),
        .wrt    (wrt),
        .cmd    (cmd),
        .vld    (vld),
        .ptch_rt(ptch_rt),
        .AZ     (AZ),
        .err    (err)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;

    logic [15:0] cmd_log[$];
    int          spi_cnt   = 0;
    logic [7:0]  pend_addr = 8'h00;
    logic [7:0]  byte_pl = 8'h34, byte_ph = 8'h12, byte_al = 8'hF0, byte_ah = 8'hFF;
    bit          drop_en   = 1'b0;
    logic [7:0]  drop_addr = 8'h00;
    int          busy_viol = 0;
    int          glitches  = 0;
    int          vld_cnt   = 0;
    logic [15:0] vld_pr = 16'h0, vld_az = 16'h0, prev_pr = 16'h0, prev_az = 16'h0;
    bit          prev_wrt  = 1'b0;

    function automatic logic [7:0] reg_byte(input logic [7:0] a);
        case (a)
            8'hA2:   return byte_pl;
            8'hA3:   return byte_ph;
            8'hAC:   return byte_al;
            8'hAD:   return byte_ah;
            default: return 8'h00;
        endcase
    endfunction

    // SPI slave model and output monitors, all on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            spi_cnt  = 0;
            done     = 1'b0;
            prev_wrt = 1'b0;
        end else begin
            done = 1'b0;
            if (wrt) begin
                cmd_log.push_back(cmd);
                if (spi_cnt != 0 || prev_wrt) busy_viol++;
                if (drop_en && cmd[15:8] == drop_addr) begin
                    drop_en = 1'b0;
                    spi_cnt = 0;
                end else begin
                    spi_cnt   = SPI_DLY - 1;
                    pend_addr = cmd[15:8];
                end
            end else if (spi_cnt > 0) begin
                spi_cnt--;
                if (spi_cnt == 0) begin
                    done    = 1'b1;
                    rd_data = {8'hEE, reg_byte(pend_addr)};
                end
            end
            prev_wrt = wrt;
            if (vld) begin
                vld_cnt++;
                vld_pr = ptch_rt;
                vld_az = AZ;
            end else if (ptch_rt !== prev_pr || AZ !== prev_az) begin
                glitches++;
            end
        end
        prev_pr = ptch_rt;
        prev_az = AZ;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] log_at(input int i);
        if (i < cmd_log.size()) return cmd_log[i];
        return 16'hxxxx;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_log(input int n, input int limit, input string tag);
        int k = 0;
        while (cmd_log.size() < n && k < limit) begin
            tick(1);
            k++;
        end
        check(tag, 32'(cmd_log.size() >= n), 32'd1);
    endtask

    task automatic wait_vld(input int n, input int limit, input string tag);
        int k = 0;
        while (vld_cnt < n && k < limit) begin
            tick(1);
            k++;
        end
        check(tag, 32'(vld_cnt >= n), 32'd1);
    endtask

    task automatic pulse_int(input int n);
        INT = 1'b1;
        tick(n);
        INT = 1'b0;
    endtask

    task automatic clear_obs();
        cmd_log.delete();
        vld_cnt = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wrt"}, 32'(wrt), 32'd0);
        check({tag, "_cmd"}, 32'(cmd), 32'h0000);
        check({tag, "_vld"}, 32'(vld), 32'd0);
        check({tag, "_ptch"}, {16'h0, $unsigned(ptch_rt)}, 32'h0000);
        check({tag, "_az"}, {16'h0, $unsigned(AZ)}, 32'h0000);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic check_init_cmds(input string tag);
        check({tag, "_c0"}, 32'(log_at(0)), 32'h0D02);
        check({tag, "_c1"}, 32'(log_at(1)), 32'h1053);
        check({tag, "_c2"}, 32'(log_at(2)), 32'h1150);
        check({tag, "_c3"}, 32'(log_at(3)), 32'h1460);
    endtask

    task automatic check_read_cmds(input string tag, input int base);
        check({tag, "_r0"}, 32'(log_at(base)),     32'hA200);
        check({tag, "_r1"}, 32'(log_at(base + 1)), 32'hA300);
        check({tag, "_r2"}, 32'(log_at(base + 2)), 32'hAC00);
        check({tag, "_r3"}, 32'(log_at(base + 3)), 32'hAD00);
    endtask

    initial begin
        int k;

        // Reset values.
        tick(3);
        check_reset_outputs("reset");

        // Power-up wait: 2^W - 1 cycles, then the init writes.
        rst_n = 1'b1;
        k = 0;
        do begin
            tick(1);
            k++;
        end while (!wrt && k < 100);
        check("first_wrt_cycle", 32'(k), 32'd15);
        check("first_wrt_cmd", 32'(cmd), 32'h0D02);
        wait_log(4, 300, "init_complete");
        check_init_cmds("init");
        tick(60);
        check("init_no_extra_wrt", 32'(cmd_log.size()), 32'd4);
        check("init_no_vld", 32'(vld_cnt), 32'd0);

        // Sample assembly, with INT-to-first-read latency.
        clear_obs();
        INT = 1'b1;
        k = 0;
        do begin
            tick(1);
            k++;
        end while (!wrt && k < 20);
        check("int_to_wrt", 32'(k), 32'd3);
        tick(3);
        INT = 1'b0;
        wait_vld(1, 300, "s1_vld_seen");
        tick(30);
        check("s1_vld_count", 32'(vld_cnt), 32'd1);
        check("s1_ptch", 32'(vld_pr), 32'h1234);
        check("s1_az", 32'(vld_az), 32'hFFF0);
        check("s1_ptch_hold", {16'h0, $unsigned(ptch_rt)}, 32'h1234);
        check("s1_log_size", 32'(cmd_log.size()), 32'd4);
        check_read_cmds("s1", 0);

        // Second INT during RD_PH is dropped; a later INT in IDLE reads normally.
        clear_obs();
        byte_pl = 8'h80; byte_ph = 8'h7F; byte_al = 8'h01; byte_ah = 8'h00;
        pulse_int(3);
        wait_log(2, 100, "s2_reach_rd_ph");
        pulse_int(3);
        tick(150);
        check("s2_reads", 32'(cmd_log.size()), 32'd4);
        check("s2_vld_count", 32'(vld_cnt), 32'd1);
        check("s2_ptch", 32'(vld_pr), 32'h7F80);
        check("s2_az", 32'(vld_az), 32'h0001);
        pulse_int(4);
        wait_vld(2, 300, "s3_vld_seen");
        tick(20);
        check("s3_reads", 32'(cmd_log.size()), 32'd8);
        check("s3_vld_count", 32'(vld_cnt), 32'd2);
        check_read_cmds("s3", 4);

        // INT held high yields one sample only.
        clear_obs();
        INT = 1'b1;
        tick(500);
        INT = 1'b0;
        tick(50);
        check("held_vld_count", 32'(vld_cnt), 32'd1);
        check("held_reads", 32'(cmd_log.size()), 32'd4);

        // Reset during RD_AL: outputs clear and init re-runs without a sample.
        clear_obs();
        pulse_int(3);
        wait_log(3, 100, "rst_reach_rd_al");
        tick(5);
        rst_n = 1'b0;
        tick(2);
        check_reset_outputs("midrst");
        clear_obs();
        rst_n = 1'b1;
        wait_log(4, 300, "reinit_complete");
        tick(50);
        check_init_cmds("reinit");
        check("reinit_no_extra_wrt", 32'(cmd_log.size()), 32'd4);
        check("reinit_no_vld", 32'(vld_cnt), 32'd0);

`ifdef INERT_TIMEOUT_EN
        // Lost done on the RD_PH read: err after 1023 cycles, abort to IDLE, then recover.
        clear_obs();
        byte_pl = 8'h34; byte_ph = 8'h12; byte_al = 8'hF0; byte_ah = 8'hFF;
        drop_en = 1'b1;
        drop_addr = 8'hA3;
        pulse_int(3);
        k = 0;
        while (!(wrt && cmd == 16'hA300) && k < 100) begin
            tick(1);
            k++;
        end
        check("to_rd_ph_issued", 32'(wrt && cmd == 16'hA300), 32'd1);
        k = 0;
        do begin
            tick(1);
            k++;
        end while (!err && k < 1100);
        check("to_err_delay", 32'(k), 32'd1023);
        tick(5);
        check("to_no_vld", 32'(vld_cnt), 32'd0);
        check("to_ptch_kept", {16'h0, $unsigned(ptch_rt)}, 32'h0000);
        check("to_az_kept", {16'h0, $unsigned(AZ)}, 32'h0000);
        check("to_reads", 32'(cmd_log.size()), 32'd2);
        pulse_int(3);
        wait_vld(1, 300, "to_recover_vld");
        tick(10);
        check("to_recover_ptch", {16'h0, $unsigned(ptch_rt)}, 32'h1234);
        check("to_recover_az", {16'h0, $unsigned(AZ)}, 32'hFFF0);
        check("to_err_sticky", 32'(err), 32'd1);
        check_read_cmds("to", 2);
`else
        check("err_tied_low", 32'(err), 32'd0);
`endif

        check("wrt_rules", 32'(busy_viol), 32'd0);
        check("output_stability", 32'(glitches), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inert_reader.md
# inert_reader

Sequencer that produces the pitch-rate and vertical-acceleration sample stream consumed by the pitch integrator. After reset it waits out the IMU power-up time, configures the IMU over the SPI master's 16-bit command interface, then on every IMU data-ready interrupt reads four register bytes. It assembles `ptch_rt` and `AZ` and pulses `vld` for one cycle. It sits between the SPI master and the inertial integrator.

## Interface
- `INIT_WAIT_W`, default 16 — width of the power-up wait counter; the first init write is issued when the counter reaches all-ones.
- `clk` in 1 — system clock; the only clock.
- `rst_n` in 1 — asynchronous active-low reset.
- `INT` in 1 — IMU data-ready pin; asynchronous to `clk`.
- `done` in 1 — SPI master transaction-complete pulse, one cycle wide.
- `rd_data` in 16 — SPI master read data; bits [7:0] hold the returned register byte and are valid in the `done` cycle.
- `wrt` out 1 — one-cycle pulse that starts an SPI transaction.
- `cmd` out 16 — SPI command word, valid in the `wrt` cycle; [15:8] is the address (bit 15 = read) and [7:0] is the write data.
- `vld` out 1 — one-cycle pulse: a new sample is present on `ptch_rt` and `AZ`.
- `ptch_rt` out 16 signed — pitch rate, raw two's complement.
- `AZ` out 16 signed — Z acceleration, raw two's complement.
- `err` out 1 — sticky SPI-timeout flag (see Configuration).

## Operation
- **Reset values:** `wrt`=0, `cmd`=16'h0000, `vld`=0, `ptch_rt`=0, `AZ`=0, `err`=0.
- **Reset state:** the FSM enters `INIT_WAIT`, the wait counter is 0, and the INT synchronizer flops are 0.
- **States:** `INIT_WAIT` → `INIT1` → `INIT2` → `INIT3` → `INIT4` → `IDLE` → `RD_PL` → `RD_PH` → `RD_AL` → `RD_AH` → `IDLE`.
- **`INIT_WAIT`:** the counter increments every cycle. When it reaches all-ones, pulse `wrt` with `cmd`=16'h0D02 (interrupt on data-ready) and go to `INIT1`.
- **Init writes:** each `INITn` waits for `done`. On `done`, issue the next write in the same cycle:
  - 16'h1053 (accel ODR)
  - 16'h1150 (gyro ODR)
  - 16'h1460 (rounding)
  - After the `done` of the last write, go to `IDLE` without issuing `wrt`.
- **`INT` handling:** `INT` passes through a 2-flop synchronizer plus a third flop used for edge detection. A sample starts on a synchronized rising edge while in `IDLE`.
- **Edges outside `IDLE`:** edges during `INIT*` or `RD_*` are dropped, not queued.
- **Reads:** on each `done` the FSM latches `rd_data[7:0]` into the matching holding byte and issues the next read in the same cycle:
  - 16'hA2xx → pitch-rate low byte
  - 16'hA3xx → pitch-rate high byte
  - 16'hACxx → AZ low byte
  - 16'hADxx → AZ high byte
  - `cmd[7:0]`=8'h00 for all reads.
- **Sample update:** on the `done` of the AZ-high read, `ptch_rt` ← {PH, PL} and `AZ` ← {AH, AL} are updated together. `vld` pulses in that same update cycle, and the FSM returns to `IDLE`.
- **Stability:** `ptch_rt` and `AZ` hold their values between `vld` pulses and never show a partially assembled sample.
- **`wrt` rules:** `wrt` is never asserted while a transaction is outstanding, and never on two consecutive cycles.
- **Stray `done`:** a `done` that arrives while in `IDLE` or `INIT_WAIT` is ignored.

## Timing
- **INT to first read:** the `INT` pin rises at edge N; the synchronized edge is detected at N+2; `wrt` for `RD_PL` is high in cycle N+3.
- **Last `done` to output:** `vld`, `ptch_rt` and `AZ` are registered and update one cycle after the sampled `done` (the cycle after the final `done`).
- **Per-sample latency:** INT edge to `vld` is 3 + 4×(SPI transaction time) + 1 cycles.
- **Power-up:** the first `wrt` occurs 2^`INIT_WAIT_W` − 1 cycles after reset deassertion.
- **Reset mid-transaction:** the FSM returns to `INIT_WAIT` immediately and the whole init sequence runs again. The SPI master is reset by the same `rst_n`.

## Configuration
- **`INERT_TIMEOUT_EN` defined:**
  - A 10-bit watchdog counts cycles in any state that is waiting for `done`, and clears on `done`.
  - When it reaches 1023, `err` is set (sticky until reset).
  - In `INIT*`, the same write is re-issued.
  - In `RD_*`, the FSM aborts to `IDLE` without pulsing `vld`; outputs keep their previous sample.
- **`INERT_TIMEOUT_EN` undefined:** there is no watchdog, `err` is tied to 0, and the FSM waits indefinitely for `done`.

## Test plan
- **Init sequence:** with `INIT_WAIT_W`=4 and an SPI model that returns `done` 20 cycles after each `wrt`, the first `wrt` occurs 15 cycles after reset. `cmd` must be 0D02, 1053, 1150, 1460 in that order, then the FSM reaches `IDLE`.
- **Sample assembly:** pulse `INT` with the model returning bytes 0x34, 0x12, 0xF0, 0xFF. This must produce a single `vld` pulse with `ptch_rt`=16'h1234 and `AZ`=16'hFFF0. The read `cmd` sequence must be A200, A300, AC00, AD00.
- **INT ignored during reads:** assert `INT` a second time during `RD_PH`. No extra reads and no second `vld` may occur; a later `INT` edge in `IDLE` produces a normal sample.
- **INT held high:** hold `INT` high for 500 cycles. Exactly one sample (one `vld`) results.
- **Reset mid-read:** assert `rst_n` low during `RD_AL`. All outputs go to their reset values, and the full init sequence re-runs with no `vld` pulse.
- **Timeout (with `INERT_TIMEOUT_EN`):** suppress `done` for the `RD_PH` read. `err` rises 1023 cycles after that `wrt`, no `vld` pulse occurs, the FSM is in `IDLE`, and the next `INT` edge reads normally.
